// File: rtl/lmc_pkg.sv
// Shared opcode and state encodings for the LMC program sequencer.
package lmc_pkg;

    localparam int OPC_W = 3;

    localparam logic [OPC_W-1:0] OP_NEXT = 3'b000;
    localparam logic [OPC_W-1:0] OP_JMP  = 3'b001;
    localparam logic [OPC_W-1:0] OP_JC   = 3'b010;
    localparam logic [OPC_W-1:0] OP_CALL = 3'b011;
    localparam logic [OPC_W-1:0] OP_RET  = 3'b100;
    localparam logic [OPC_W-1:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        ST_STOP  = 2'b00,
        ST_RUN   = 2'b01,
        ST_HALT  = 2'b10,
        ST_FAULT = 2'b11
    } state_e;

endpackage

// File: rtl/lmc_call_stack.sv
// Hardware return-address LIFO for CALL/RET. Only the occupancy count is reset;
// entry storage is plain registers.
module lmc_call_stack #(
    parameter int ADDR_WIDTH  = 4,
    parameter int STACK_DEPTH = 4,
    parameter int SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  srst_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [ADDR_WIDTH-1:0] push_data_i,
    output logic [ADDR_WIDTH-1:0] top_o,
    output logic [SP_W-1:0]       sp_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_WIDTH-1:0] entry_q [2**IDX_W];
    logic [SP_W-1:0]       sp_q;
    logic [SP_W-1:0]       sp_d;
    logic [IDX_W-1:0]      wr_idx_s;
    logic [IDX_W-1:0]      rd_idx_s;

    assign full_o   = (sp_q == SP_W'(STACK_DEPTH));
    assign empty_o  = (sp_q == {SP_W{1'b0}});
    assign wr_idx_s = IDX_W'(sp_q);
    assign rd_idx_s = IDX_W'(sp_q - SP_W'(1));
    assign top_o    = entry_q[rd_idx_s];
    assign sp_o     = sp_q;

    // Occupancy next-state; a push on a full stack or pop on an empty one is dropped.
    always_comb begin
        sp_d = sp_q;
        if (srst_i) begin
            sp_d = {SP_W{1'b0}};
        end else if (push_i && !full_o) begin
            sp_d = sp_q + SP_W'(1);
        end else if (pop_i && !empty_o) begin
            sp_d = sp_q - SP_W'(1);
        end else begin
            sp_d = sp_q;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sp_q <= {SP_W{1'b0}};
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o && !srst_i) begin
            entry_q[wr_idx_s] <= push_data_i;
        end
    end

endmodule

// File: rtl/lmc_seq_ram.sv
// LMC program sequencer with integrated program RAM, return stack and
// STOP/RUN/HALT/FAULT control.
module lmc_seq_ram
    import lmc_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                               timer555,
    input  logic                               reset_count,
    input  logic                               restart,
    input  logic                               run,
    input  logic                               cond_in,
    input  logic                               prog_mode,
    input  logic                               wr_en,
    input  logic [ADDR_WIDTH-1:0]              wr_addr,
    input  logic [DATA_WIDTH-1:0]              data_in,
    output logic [ADDR_WIDTH-1:0]              pc,
    output logic [DATA_WIDTH-1:0]              RAM_out,
    output logic [1:0]                         state,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               fault
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    state_e                state_q;
    state_e                state_d;
    logic                  fault_q;

    logic [OPC_W-1:0]      opcode_s;
    logic [ADDR_WIDTH-1:0] target_s;
    logic [ADDR_WIDTH-1:0] pc_inc_s;
    logic                  push_s;
    logic                  pop_s;
    logic [ADDR_WIDTH-1:0] stk_top_s;
    logic                  stk_full_s;
    logic                  stk_empty_s;
    logic [SP_W-1:0]       sp_s;

    assign RAM_out  = mem_q[pc_q];
    assign opcode_s = RAM_out[DATA_WIDTH-1 -: OPC_W];
    assign target_s = RAM_out[ADDR_WIDTH-1:0];
    assign pc_inc_s = pc_q + ADDR_WIDTH'(1);

    lmc_call_stack #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .STACK_DEPTH (STACK_DEPTH),
        .SP_W        (SP_W)
    ) u_call_stack (
        .clk_i       (timer555),
        .rst_i       (reset_count),
        .srst_i      (restart),
        .push_i      (push_s),
        .pop_i       (pop_s),
        .push_data_i (pc_inc_s),
        .top_o       (stk_top_s),
        .sp_o        (sp_s),
        .full_o      (stk_full_s),
        .empty_o     (stk_empty_s)
    );

    // Program RAM write port; locked out while executing so code cannot be patched mid-run.
    always_ff @(posedge timer555) begin
        if (wr_en && (state_q != ST_RUN)) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    // Next pc/state and stack requests; mode changes pre-empt the instruction at pc.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        if (restart) begin
            pc_d    = {ADDR_WIDTH{1'b0}};
            state_d = ST_STOP;
        end else begin
            case (state_q)
                ST_STOP: begin
                    if (run && !prog_mode) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_STOP;
                    end
                end
                ST_RUN: begin
                    if (prog_mode || !run) begin
                        state_d = ST_STOP;
                    end else begin
                        case (opcode_s)
                            OP_NEXT: pc_d = pc_inc_s;
                            OP_JMP:  pc_d = target_s;
                            OP_JC:   pc_d = cond_in ? target_s : pc_inc_s;
                            OP_CALL: begin
                                if (stk_full_s) begin
                                    state_d = ST_FAULT;
                                end else begin
                                    push_s = 1'b1;
                                    pc_d   = target_s;
                                end
                            end
                            OP_RET: begin
                                if (stk_empty_s) begin
                                    state_d = ST_FAULT;
                                end else begin
                                    pop_s = 1'b1;
                                    pc_d  = stk_top_s;
                                end
                            end
                            OP_HALT: state_d = ST_HALT;
                            default: pc_d = pc_inc_s;
                        endcase
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Sequencer state register; fault is registered alongside state.
    always_ff @(posedge timer555 or posedge reset_count) begin
        if (reset_count) begin
            pc_q    <= {ADDR_WIDTH{1'b0}};
            state_q <= ST_STOP;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            fault_q <= (state_d == ST_FAULT);
        end
    end

    assign pc    = pc_q;
    assign state = state_q;
    assign sp    = sp_s;
    assign fault = fault_q;

endmodule

// File: tb/tb_lmc_seq_ram.sv
// Bench for lmc_seq_ram: directed vector table, hand-written corner sequences
// and randomized stimulus against a queue-based reference model.
module tb_lmc_seq_ram;

    logic       timer555 = 1'b0;
    logic       reset_count, restart, run, cond_in, prog_mode, wr_en;
    logic [3:0] wr_addr;
    logic [7:0] data_in;
    logic [3:0] pc;
    logic [7:0] RAM_out;
    logic [1:0] state;
    logic [2:0] sp;
    logic       fault;

    lmc_seq_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .STACK_DEPTH(4)) dut (
        .timer555(timer555), .reset_count(reset_count), .restart(restart),
        .run(run), .cond_in(cond_in), .prog_mode(prog_mode), .wr_en(wr_en),
        .wr_addr(wr_addr), .data_in(data_in), .pc(pc), .RAM_out(RAM_out),
        .state(state), .sp(sp), .fault(fault)
    );

    always #5 timer555 = ~timer555;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: 0 STOP, 1 RUN, 2 HALT, 3 FAULT
    logic [7:0] m_mem [16];
    int         m_pc;
    int         m_st;
    int         m_stk [$];

    typedef struct {
        logic       run, cond, prog, wr, rst;
        logic [3:0] waddr;
        logic [7:0] wdata;
        logic [3:0] pc;
        logic [1:0] st;
        logic [2:0] sp;
        logic       chk_ram;
        logic [7:0] ram;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic r, c, p, w, rs, input logic [3:0] wa,
                                input logic [7:0] wd, input logic [3:0] epc,
                                input logic [1:0] est, input logic [2:0] esp,
                                input logic cr, input logic [7:0] er);
        vec_t v;
        v.run = r; v.cond = c; v.prog = p; v.wr = w; v.rst = rs;
        v.waddr = wa; v.wdata = wd; v.pc = epc; v.st = est; v.sp = esp;
        v.chk_ram = cr; v.ram = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        logic [7:0] ins;
        int t, nx;
        ins = m_mem[m_pc];
        t   = int'(ins[3:0]);
        nx  = (m_pc + 1) % 16;
        if (wr_en && m_st != 1) m_mem[wr_addr] = data_in;
        if (restart) begin
            m_pc = 0; m_st = 0; m_stk.delete();
        end else if (m_st == 0) begin
            if (run && !prog_mode) m_st = 1;
        end else if (m_st == 1) begin
            if (prog_mode || !run) m_st = 0;
            else begin
                case (ins[7:5])
                    3'd1: m_pc = t;
                    3'd2: m_pc = cond_in ? t : nx;
                    3'd3: if (m_stk.size() == 4) m_st = 3;
                          else begin m_stk.push_back(nx); m_pc = t; end
                    3'd4: if (m_stk.size() == 0) m_st = 3;
                          else m_pc = m_stk.pop_back();
                    3'd7: m_st = 2;
                    default: m_pc = nx;
                endcase
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge timer555);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, " pc"},    32'(pc),      32'(m_pc));
        chk({tag, " state"}, 32'(state),   32'(m_st));
        chk({tag, " sp"},    32'(sp),      32'(m_stk.size()));
        chk({tag, " fault"}, 32'(fault),   32'(m_st == 3));
        chk({tag, " ram"},   32'(RAM_out), 32'(m_mem[m_pc]));
    endtask

    task automatic write_mem(input logic [3:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; data_in = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        reset_count = 1'b1; restart = 1'b0; run = 1'b0; cond_in = 1'b0;
        prog_mode = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; data_in = 8'd0;
        m_pc = 0; m_st = 0;
        @(posedge timer555);
        #1;
        chk("reset pc", 32'(pc), 32'd0);
        chk("reset state", 32'(state), 32'd0);
        chk("reset sp", 32'(sp), 32'd0);
        chk("reset fault", 32'(fault), 32'd0);
        reset_count = 1'b0;

        for (int i = 0; i < 16; i++) write_mem(4'(i), 8'h00);

        // run cond prog wr rst waddr wdata | pc st sp chk ram
        tbl.push_back(mk(0,0,0,1,0, 4'd0, 8'h00, 4'd0,  2'd0, 3'd0, 1, 8'h00));
        tbl.push_back(mk(0,0,0,1,0, 4'd1, 8'h25, 4'd0,  2'd0, 3'd0, 0, 8'h00));
        tbl.push_back(mk(0,0,0,1,0, 4'd5, 8'hE0, 4'd0,  2'd0, 3'd0, 0, 8'h00));
        tbl.push_back(mk(1,0,0,0,0, 4'd0, 8'h00, 4'd0,  2'd1, 3'd0, 1, 8'h00));
        tbl.push_back(mk(1,0,0,0,0, 4'd0, 8'h00, 4'd1,  2'd1, 3'd0, 1, 8'h25));
        tbl.push_back(mk(1,0,0,0,0, 4'd0, 8'h00, 4'd5,  2'd1, 3'd0, 1, 8'hE0));
        tbl.push_back(mk(1,0,0,0,0, 4'd0, 8'h00, 4'd5,  2'd2, 3'd0, 1, 8'hE0));
        tbl.push_back(mk(1,0,0,0,0, 4'd0, 8'h00, 4'd5,  2'd2, 3'd0, 0, 8'h00));
        tbl.push_back(mk(1,0,0,0,1, 4'd0, 8'h00, 4'd0,  2'd0, 3'd0, 1, 8'h00));
        tbl.push_back(mk(0,0,0,1,0, 4'd0, 8'h69, 4'd0,  2'd0, 3'd0, 1, 8'h69));
        tbl.push_back(mk(0,0,0,1,0, 4'd9, 8'h80, 4'd0,  2'd0, 3'd0, 0, 8'h00));
        tbl.push_back(mk(0,0,0,1,0, 4'd1, 8'hE0, 4'd0,  2'd0, 3'd0, 0, 8'h00));
        tbl.push_back(mk(1,0,0,0,0, 4'd0, 8'h00, 4'd0,  2'd1, 3'd0, 1, 8'h69));
        tbl.push_back(mk(1,0,0,0,0, 4'd0, 8'h00, 4'd9,  2'd1, 3'd1, 1, 8'h80));
        tbl.push_back(mk(1,0,0,0,0, 4'd0, 8'h00, 4'd1,  2'd1, 3'd0, 1, 8'hE0));
        tbl.push_back(mk(1,0,0,0,0, 4'd0, 8'h00, 4'd1,  2'd2, 3'd0, 0, 8'h00));
        tbl.push_back(mk(0,0,0,0,1, 4'd0, 8'h00, 4'd0,  2'd0, 3'd0, 0, 8'h00));
        tbl.push_back(mk(0,0,0,1,0, 4'd0, 8'h00, 4'd0,  2'd0, 3'd0, 1, 8'h00));
        tbl.push_back(mk(0,0,0,1,0, 4'd1, 8'h00, 4'd0,  2'd0, 3'd0, 0, 8'h00));
        tbl.push_back(mk(0,0,0,1,0, 4'd2, 8'h4A, 4'd0,  2'd0, 3'd0, 0, 8'h00));
        tbl.push_back(mk(1,0,0,0,0, 4'd0, 8'h00, 4'd0,  2'd1, 3'd0, 0, 8'h00));
        tbl.push_back(mk(1,0,0,0,0, 4'd0, 8'h00, 4'd1,  2'd1, 3'd0, 0, 8'h00));
        tbl.push_back(mk(1,0,0,0,0, 4'd0, 8'h00, 4'd2,  2'd1, 3'd0, 1, 8'h4A));
        tbl.push_back(mk(1,0,0,1,0, 4'd3, 8'hAA, 4'd3,  2'd1, 3'd0, 1, 8'h00));
        tbl.push_back(mk(1,0,1,0,0, 4'd0, 8'h00, 4'd3,  2'd0, 3'd0, 1, 8'h00));
        tbl.push_back(mk(1,0,1,1,0, 4'd3, 8'hAA, 4'd3,  2'd0, 3'd0, 1, 8'hAA));
        tbl.push_back(mk(0,0,0,0,1, 4'd0, 8'h00, 4'd0,  2'd0, 3'd0, 0, 8'h00));
        tbl.push_back(mk(1,0,0,0,0, 4'd0, 8'h00, 4'd0,  2'd1, 3'd0, 0, 8'h00));
        tbl.push_back(mk(1,0,0,0,0, 4'd0, 8'h00, 4'd1,  2'd1, 3'd0, 0, 8'h00));
        tbl.push_back(mk(1,0,0,0,0, 4'd0, 8'h00, 4'd2,  2'd1, 3'd0, 0, 8'h00));
        tbl.push_back(mk(1,1,0,0,0, 4'd0, 8'h00, 4'd10, 2'd1, 3'd0, 1, 8'h00));
        for (int p = 11; p <= 16; p++)
            tbl.push_back(mk(1,0,0,0,0, 4'd0, 8'h00, 4'(p), 2'd1, 3'd0, 1, 8'h00));

        foreach (tbl[i]) begin
            run = tbl[i].run; cond_in = tbl[i].cond; prog_mode = tbl[i].prog;
            wr_en = tbl[i].wr; restart = tbl[i].rst;
            wr_addr = tbl[i].waddr; data_in = tbl[i].wdata;
            tick();
            chk($sformatf("vec%0d pc", i), 32'(pc), 32'(tbl[i].pc));
            chk($sformatf("vec%0d state", i), 32'(state), 32'(tbl[i].st));
            chk($sformatf("vec%0d sp", i), 32'(sp), 32'(tbl[i].sp));
            if (tbl[i].chk_ram)
                chk($sformatf("vec%0d ram", i), 32'(RAM_out), 32'(tbl[i].ram));
        end
        run = 1'b0; cond_in = 1'b0; prog_mode = 1'b0; wr_en = 1'b0; restart = 1'b0;

        // Stack overflow: CALL 0 repeatedly
        restart = 1'b1; tick(); restart = 1'b0;
        write_mem(4'd0, 8'h60);
        run = 1'b1; tick();
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("ovf call%0d sp", k), 32'(sp), 32'(k));
        end
        tick();
        chk("ovf state", 32'(state), 32'd3);
        chk("ovf fault", 32'(fault), 32'd1);
        chk("ovf pc", 32'(pc), 32'd0);
        chk("ovf sp", 32'(sp), 32'd4);
        tick();
        chk("ovf sticky state", 32'(state), 32'd3);
        restart = 1'b1; run = 1'b0; tick(); restart = 1'b0;
        chk("ovf restart fault", 32'(fault), 32'd0);
        chk("ovf restart sp", 32'(sp), 32'd0);

        // Underflow: RET with empty stack
        write_mem(4'd0, 8'h80);
        run = 1'b1; tick(); tick();
        chk("unf state", 32'(state), 32'd3);
        chk("unf fault", 32'(fault), 32'd1);
        chk("unf sp", 32'(sp), 32'd0);

        // Async reset mid-cycle at pc=6, sp=2
        restart = 1'b1; run = 1'b0; tick(); restart = 1'b0;
        write_mem(4'd0, 8'h63);
        write_mem(4'd3, 8'h65);
        write_mem(4'd5, 8'h00);
        run = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("arst pre pc", 32'(pc), 32'd6);
        chk("arst pre sp", 32'(sp), 32'd2);
        #2 reset_count = 1'b1;
        #1;
        chk("arst pc", 32'(pc), 32'd0);
        chk("arst sp", 32'(sp), 32'd0);
        chk("arst state", 32'(state), 32'd0);
        m_pc = 0; m_st = 0; m_stk.delete();
        reset_count = 1'b0; run = 1'b0;

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            restart   = ($urandom_range(0, 31) == 0);
            prog_mode = ($urandom_range(0, 15) == 0);
            run       = ($urandom_range(0, 7) != 0);
            cond_in   = 1'($urandom);
            wr_en     = ($urandom_range(0, 2) == 0);
            wr_addr   = 4'($urandom);
            data_in   = 8'($urandom);
            tick();
            cmp_model($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
